// File: rtl/branch_pkg.sv
// Shared encodings for the branch predictor: op codes, redirect selects,
// 2-bit counter states and funct3 branch conditions.
package branch_pkg;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_JUMP = 2'b01;
  localparam logic [1:0] BR_COND = 2'b10;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_TARGET = 2'b01;
  localparam logic [1:0] RES_PLUS4  = 2'b10;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Saturating step of a 2-bit direction counter.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == ST) ? ST : cnt + 2'd1;
    end
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_counter_table.sv
// Table of 2-bit saturating direction counters: combinational read of the
// prediction bit, one synchronous training port.
module branch_counter_table
  import branch_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_taken_o,
  input  logic                upd_en_i,
  input  logic [IDX_BITS-1:0] upd_idx_i,
  input  logic                upd_taken_i
);

  localparam int unsigned DEPTH = 2 ** IDX_BITS;

  logic [1:0] cnt_q [DEPTH];
  logic [1:0] upd_cnt_d;

  assign rd_taken_o = cnt_q[rd_idx_i][1];
  assign upd_cnt_d  = sat_update(cnt_q[upd_idx_i], upd_taken_i);

  // Reset takes priority over any same-cycle training write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= WNT;
      end
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= upd_cnt_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direction predictor with Execute-stage resolution, redirect select,
// counter training and performance counters.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int unsigned IDX_BITS  = 6,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          PCF,
  output logic                 PCSrcPredF,
  input  logic [31:0]          PCE,
  input  logic [31:0]          PCTargetE,
  input  logic [31:0]          PCPlus4E,
  input  logic [1:0]           BranchOpE,
  input  logic [2:0]           funct3E,
  input  logic                 N,
  input  logic                 Z,
  input  logic                 C,
  input  logic                 V,
  input  logic                 PCSrcPredE,
  input  logic                 TargetMatchE,
  input  logic                 StallE,
  output logic                 MispredictE,
  output logic [1:0]           PCSrcResE,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MispredictCount
);

  logic                 taken_e;
  logic                 valid_e;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;
  logic                 unused_bits;

  // Targets are consumed by the fetch mux; only the PC index bits matter here.
  assign unused_bits = ^{PCF[31:IDX_BITS+2], PCF[1:0], PCE[31:IDX_BITS+2], PCE[1:0],
                         PCTargetE, PCPlus4E};

  branch_counter_table #(
    .IDX_BITS(IDX_BITS)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (PCF[IDX_BITS+1:2]),
    .rd_taken_o (PCSrcPredF),
    .upd_en_i   (valid_e),
    .upd_idx_i  (PCE[IDX_BITS+1:2]),
    .upd_taken_i(taken_e)
  );

  // Actual direction of the Execute-stage instruction.
  always_comb begin
    taken_e = 1'b0;
    case (BranchOpE)
      BR_JUMP: taken_e = 1'b1;
      BR_COND: begin
        case (funct3E)
          F3_BEQ:  taken_e = Z;
          F3_BNE:  taken_e = ~Z;
          F3_BLT:  taken_e = N ^ V;
          F3_BGE:  taken_e = ~(N ^ V);
          F3_BLTU: taken_e = ~C;
          F3_BGEU: taken_e = C;
          default: taken_e = 1'b0;
        endcase
      end
      default: taken_e = 1'b0;
    endcase
  end

  assign valid_e     = ((BranchOpE == BR_JUMP) | (BranchOpE == BR_COND)) & ~StallE;
  assign MispredictE = valid_e & ((taken_e != PCSrcPredE) | (taken_e & ~TargetMatchE));

  always_comb begin
    PCSrcResE = RES_NONE;
    if (MispredictE) begin
      PCSrcResE = taken_e ? RES_TARGET : RES_PLUS4;
    end
  end

  assign branch_cnt_d  = branch_cnt_q + CNT_WIDTH'(valid_e);
  assign mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(MispredictE);

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: resolution vector table plus
// hand-written training, stall and reset sequences.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF, PCE, PCTargetE, PCPlus4E;
  logic        PCSrcPredF;
  logic [1:0]  BranchOpE;
  logic [2:0]  funct3E;
  logic        N, Z, C, V;
  logic        PCSrcPredE, TargetMatchE, StallE;
  logic        MispredictE;
  logic [1:0]  PCSrcResE;
  logic [31:0] BranchCount, MispredictCount;

  int n_vec = 0;
  int n_err = 0;
  int exp_bc = 0;
  int exp_mc = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(6), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .PCSrcPredF(PCSrcPredF),
    .PCE(PCE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
    .BranchOpE(BranchOpE), .funct3E(funct3E), .N(N), .Z(Z), .C(C), .V(V),
    .PCSrcPredE(PCSrcPredE), .TargetMatchE(TargetMatchE), .StallE(StallE),
    .MispredictE(MispredictE), .PCSrcResE(PCSrcResE),
    .BranchCount(BranchCount), .MispredictCount(MispredictCount)
  );

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] f3;
    logic       n, z, c, v;
    logic       pred, tm, stall;
    logic       exp_mis;
    logic [1:0] exp_res;
    logic       exp_valid;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                       input logic n, input logic z, input logic c, input logic v,
                       input logic pred, input logic tm, input logic stall,
                       input logic [31:0] pce);
    BranchOpE = op; funct3E = f3; N = n; Z = z; C = c; V = v;
    PCSrcPredE = pred; TargetMatchE = tm; StallE = stall; PCE = pce;
    PCTargetE = pce + 32'h20; PCPlus4E = pce + 32'h4;
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_bc = 0;
    exp_mc = 0;
  endtask

  task automatic check_counts(input string name);
    check({name, "_bc"}, BranchCount, 32'(exp_bc));
    check({name, "_mc"}, MispredictCount, 32'(exp_mc));
  endtask

  task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
    PCF = pc;
    #1;
    check(name, {31'b0, PCSrcPredF}, {31'b0, exp});
  endtask

  initial begin
    // op, f3, N Z C V, pred, tm, stall, exp_mis, exp_res, exp_valid
    vecs[0]  = '{2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1}; // BEQ taken, pred NT
    vecs[1]  = '{2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[2]  = '{2'b10, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[3]  = '{2'b10, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1};
    vecs[4]  = '{2'b10, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1};
    vecs[5]  = '{2'b10, 3'b100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[6]  = '{2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1}; // BGE N=V=1
    vecs[7]  = '{2'b10, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1};
    vecs[8]  = '{2'b10, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1}; // wrong target
    vecs[9]  = '{2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1}; // BLTU C=1
    vecs[10] = '{2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[11] = '{2'b10, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1};
    vecs[12] = '{2'b10, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1}; // undefined f3
    vecs[13] = '{2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1}; // JAL bad target
    vecs[14] = '{2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1};
    vecs[15] = '{2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[16] = '{2'b00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0}; // bubble
    vecs[17] = '{2'b11, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[18] = '{2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0}; // stalled

    reset = 1'b1;
    PCF = 32'h0;
    idle();
    do_reset();

    // All counters start weak-NT.
    for (int i = 0; i < 64; i++) begin
      check_pred($sformatf("reset_pred_%0d", i), 32'(i) << 2, 1'b0);
    end
    check_counts("reset");

    // Train index of 0x40 up to strong-T, then back down.
    PCF = 32'h40;
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40);
      check($sformatf("beq_mis_%0d", k), {31'b0, MispredictE}, 32'd1);
      check($sformatf("beq_res_%0d", k), {30'b0, PCSrcResE}, 32'd1);
      tick();
      exp_bc++; exp_mc++;
      idle();
      check_pred($sformatf("beq_pred_%0d", k), 32'h40, 1'b1);
    end
    drive(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
    check("beq_nt_res", {30'b0, PCSrcResE}, 32'd2);
    tick();
    exp_bc++; exp_mc++;
    idle();
    check_pred("beq_nt_pred_wt", 32'h40, 1'b1);
    drive(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
    tick();
    exp_bc++; exp_mc++;
    idle();
    check_pred("beq_nt_pred_wnt", 32'h40, 1'b0);
    check_counts("train");

    // Held taken branch trains once, on release.
    drive(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall_mis_%0d", k), {31'b0, MispredictE}, 32'd0);
      tick();
      check_pred($sformatf("stall_pred_%0d", k), 32'h80, 1'b0);
      check_counts($sformatf("stall_%0d", k));
    end
    StallE = 1'b0;
    #1;
    check("release_mis", {31'b0, MispredictE}, 32'd1);
    tick();
    exp_bc++; exp_mc++;
    idle();
    check_pred("release_pred", 32'h80, 1'b1);
    check_counts("release");
    drive(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
    tick();
    exp_bc++;
    idle();
    check_pred("release_once", 32'h80, 1'b0);

    // Same-cycle update and lookup of one index returns the old prediction.
    drive(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
    check_pred("bypass_old", 32'h100, 1'b0);
    tick();
    exp_bc++; exp_mc++;
    check_pred("bypass_new", 32'h100, 1'b1);

    // Reset beats a mispredicted taken branch sitting in Execute.
    drive(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    exp_bc = 0; exp_mc = 0;
    check_pred("rst_mid_pred", 32'h100, 1'b0);
    check_pred("rst_mid_pred40", 32'h40, 1'b0);
    check_counts("rst_mid");
    drive(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
    tick();
    exp_bc++; exp_mc++;
    idle();
    check_pred("rst_mid_wnt", 32'h100, 1'b1);
    check_counts("rst_after");

    // Resolution vector table.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].n, vecs[i].z, vecs[i].c, vecs[i].v,
            vecs[i].pred, vecs[i].tm, vecs[i].stall, 32'h200 + 32'(i) * 32'd4);
      check($sformatf("vec%0d_mis", i), {31'b0, MispredictE}, {31'b0, vecs[i].exp_mis});
      check($sformatf("vec%0d_res", i), {30'b0, PCSrcResE}, {30'b0, vecs[i].exp_res});
      tick();
      if (vecs[i].exp_valid) exp_bc++;
      if (vecs[i].exp_mis) exp_mc++;
      check_counts($sformatf("vec%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
